// File: rtl/sd_iosync_c.sv
// sd_iosync_c: transmit-domain half of the srdy/drdy clock-crossing synchronizer.
// Each accepted word is presented on s_data and handed across with a four-phase
// req/ack handshake; s_ack is brought in through a two-flop synchronizer.
// Optional hold buffer: define SD_IOSYNC_C_PREFETCH_EN.
module sd_iosync_c #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             s_req,
  input  logic             s_ack,
  output logic [width-1:0] s_data
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SETUP = 4'b0010,
    REQ   = 4'b0100,
    DROP  = 4'b1000
  } state_t;

  state_t             state_q, state_d;
  logic               ack_sync1, ack_sync2;
  logic               s_req_q, s_req_d;
  logic [width-1:0]   s_data_q, s_data_d;
  logic               c_drdy_q, c_drdy_d;
  logic               xfer;

`ifdef SD_IOSYNC_C_PREFETCH_EN
  logic [width-1:0]   hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
`endif

  assign xfer   = c_srdy & c_drdy_q;
  assign c_drdy = c_drdy_q;
  assign s_req  = s_req_q;
  assign s_data = s_data_q;

  // Two-flop synchronizer on the far-domain acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync1 <= 1'b0;
      ack_sync2 <= 1'b0;
    end else begin
      ack_sync1 <= s_ack;
      ack_sync2 <= ack_sync1;
    end
  end

  // State, request, data and ready registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_req_q  <= 1'b0;
      s_data_q <= '0;
      c_drdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      s_req_q  <= s_req_d;
      s_data_q <= s_data_d;
      c_drdy_q <= c_drdy_d;
    end
  end

`ifdef SD_IOSYNC_C_PREFETCH_EN
  // Hold buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  // Next-state, load and ready decode; s_req is high exactly while in REQ.
  always_comb begin
    state_d  = state_q;
    s_data_d = s_data_q;
`ifdef SD_IOSYNC_C_PREFETCH_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          s_data_d     = hold_q;
          hold_valid_d = 1'b0;
          state_d      = SETUP;
        end else if (xfer) begin
          s_data_d = c_data;
          state_d  = SETUP;
        end
      end
      SETUP: if (!ack_sync2) state_d = REQ;
      REQ:   if (ack_sync2)  state_d = DROP;
      DROP: begin
        if (!ack_sync2) begin
          // Skip the IDLE cycle when a word is already waiting.
          if (hold_valid_q) begin
            s_data_d     = hold_q;
            hold_valid_d = 1'b0;
            state_d      = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Outside IDLE an accepted word parks in the hold buffer (only possible when empty).
    if (xfer && (state_q != IDLE)) begin
      hold_d       = c_data;
      hold_valid_d = 1'b1;
    end
    c_drdy_d = !hold_valid_d;
`else
    case (state_q)
      IDLE: begin
        if (xfer) begin
          s_data_d = c_data;
          state_d  = SETUP;
        end
      end
      SETUP: if (!ack_sync2) state_d = REQ;
      REQ:   if (ack_sync2)  state_d = DROP;
      DROP:  if (!ack_sync2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    c_drdy_d = (state_d == IDLE);
`endif
    s_req_d = (state_d == REQ);
  end

endmodule

// File: tb/tb_sd_iosync_c.sv
// Bench for sd_iosync_c: directed words, scoreboard popped at each s_req rise.
module tb_sd_iosync_c;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_srdy;
  logic       c_drdy;
  logic [7:0] c_data;
  logic       s_req;
  logic       s_ack;
  logic [7:0] s_data;

  int         checks = 0;
  int         errors = 0;
  int         delivered = 0;
  int         sent = 0;
  logic [7:0] exp_q[$];
  bit         auto_ack = 1'b0;
  logic       req_prev = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] exp_w;

  sd_iosync_c #(.width(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .s_req  (s_req),
    .s_ack  (s_ack),
    .s_data (s_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Far-side responder: s_ack follows s_req one half-cycle later when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack) s_ack = s_req;
    end
  end

  // Monitor: each new request must carry the next expected word, held stable while high.
  always @(negedge clk) begin
    if (s_req && !req_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: got %0h expected none", s_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (s_data !== exp_w) begin
          errors++;
          $display("FAIL req_data: got %0h expected %0h", s_data, exp_w);
        end
        delivered++;
      end
      held = s_data;
    end else if (s_req && (s_data !== held)) begin
      checks++;
      errors++;
      $display("FAIL data_stable: got %0h expected %0h", s_data, held);
    end
    req_prev = s_req;
  end

  // Wait (bounded) for c_drdy, then present one word for a single cycle.
  task automatic send_word(input logic [7:0] w);
    int n = 0;
    while (!c_drdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drdy_wait", 32'(c_drdy), 32'd1);
    if (c_drdy) begin
      c_srdy = 1'b1;
      c_data = w;
      exp_q.push_back(w);
      sent++;
      @(negedge clk);
      c_srdy = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || s_req) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(n < 1000), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!s_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", 32'(s_req), 32'd1);
  endtask

  initial begin
    logic [7:0] stream [8];
    stream = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'h7E, 8'hC3};
    reset  = 1'b1;
    c_srdy = 1'b1;
    c_data = 8'hEE;
    s_ack  = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    c_srdy = 1'b0;
    @(negedge clk);
    chk("rst_drdy",  32'(c_drdy), 32'd1);
    chk("rst_req",   32'(s_req),  32'd0);
    chk("rst_data",  32'(s_data), 32'h00);
    auto_ack = 1'b1;

`ifdef SD_IOSYNC_C_PREFETCH_EN
    // Back-to-back words with the hold buffer.
    send_word(8'h11);
    wait_req();
    chk("pf_drdy_in_req", 32'(c_drdy), 32'd1);
    send_word(8'h22);
    chk("pf_drdy_full", 32'(c_drdy), 32'd0);
    chk("pf_data_held", 32'(s_data), 32'h11);
    begin
      int n = 0;
      while (!c_drdy && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pf_drdy_back", 32'(c_drdy), 32'd1);
    chk("pf_data_moved", 32'(s_data), 32'h22);
    send_word(8'h33);
    wait_idle();
`else
    // Single word: exact handshake timing.
    send_word(8'h5A);
    chk("sw_data",  32'(s_data), 32'h5A);
    chk("sw_drdy0", 32'(c_drdy), 32'd0);
    chk("sw_req_t0", 32'(s_req), 32'd0);
    @(negedge clk); chk("sw_req_t1", 32'(s_req), 32'd1);
    @(negedge clk); chk("sw_req_t2", 32'(s_req), 32'd1);
    @(negedge clk); chk("sw_req_t3", 32'(s_req), 32'd1);
    @(negedge clk); chk("sw_req_t4", 32'(s_req), 32'd0);
    @(negedge clk); chk("sw_drdy_t5", 32'(c_drdy), 32'd0);
    @(negedge clk); chk("sw_drdy_t6", 32'(c_drdy), 32'd0);
    @(negedge clk); chk("sw_drdy_t7", 32'(c_drdy), 32'd1);
    chk("sw_data_hold", 32'(s_data), 32'h5A);

    // Stale ack high across reset release.
    auto_ack = 1'b0;
    s_ack    = 1'b1;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send_word(8'hC3);
    chk("stale_data", 32'(s_data), 32'hC3);
    repeat (4) begin
      @(negedge clk);
      chk("stale_hold", 32'(s_req), 32'd0);
    end
    s_ack = 1'b0;
    @(negedge clk); chk("stale_x1", 32'(s_req), 32'd0);
    @(negedge clk); chk("stale_x2", 32'(s_req), 32'd0);
    @(negedge clk); chk("stale_x3", 32'(s_req), 32'd1);
    auto_ack = 1'b1;
    wait_idle();

    // Reset while s_req is high, then a fresh word.
    send_word(8'h77);
    wait_req();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req",  32'(s_req),  32'd0);
    chk("midrst_drdy", 32'(c_drdy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    send_word(8'h3C);
    wait_idle();
`endif

    // Stream of words with irregular gaps.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_word(stream[i]);
    end
    wait_idle();
    chk("count", 32'(delivered), 32'(sent));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
